module_demux_1x4_reg: RTL
=========================

# module_demux_1x4_reg

Registered 1-to-4 demultiplexer with valid/ready handshake: the inverse of the datapath 4x1 mux. One input channel is steered to one of four output channels, selected either by the 2-bit select field ({s1,s0}) or by an internal round-robin pointer. Each output owns a one-entry register slot, so every path is registered. Sits on the write-back/forwarding side of the MIPS32 datapath, where one result stream fans out to four consumers.

## Interface
- WIDTH, 32: data width of the input and of each output.
- COUNT_W, 16: width of the accepted-transfer counter.

- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  2  target output in select mode; {s1,s0}: 00→0, 01→1, 10→2, 11→3.
- rr_en  input  1  1 = round-robin steering, 0 = select steering.
- out_valid  output  4  bit k: slot k holds a word.
- out_ready  input  4  bit k: consumer k takes slot k this cycle.
- out_data0..out_data3  output  WIDTH each  slot contents.
- xfer_count  output  COUNT_W  accepted input transfers, wraps modulo 2^COUNT_W.

## Operation
- Target index T = rr_en ? rr_ptr : in_sel. rr_ptr is a 2-bit internal register.
- Slot k is free when out_valid[k]==0 or out_ready[k]==1.
- in_ready = slot T free. It is combinational from rr_en, in_sel, rr_ptr, out_valid and out_ready. It does not depend on in_valid.
- Accept when in_valid && in_ready:
  - slot T loads in_data and sets out_valid[T];
  - xfer_count increments;
  - if rr_en==1, rr_ptr advances by 1 and wraps 3→0.
- Pop: when out_valid[k] && out_ready[k], slot k is consumed. If it is not reloaded in the same cycle, out_valid[k] clears. out_data[k] keeps its stale value after a pop.
- Same slot popped and pushed in one cycle: the new word loads and out_valid[k] stays 1. No bubble.
- Pops on non-target slots proceed independently and in parallel.
- If in_valid && !in_ready, nothing changes for the input side. The source must hold in_valid, in_data and in_sel stable until accepted.
- rr_ptr advances only on accepted transfers while rr_en==1. It holds its value while rr_en==0.
- Toggling rr_en changes T in the same cycle. There is no flush.
- xfer_count wraps to 0 after reaching 2^COUNT_W−1.

## Timing
- Reset (async assert, released synchronously to clk by the top level): out_valid=0000, out_data0..3=0, rr_ptr=0, xfer_count=0. in_ready therefore reads 1 immediately.
- Reset mid-operation drops all held words; no output handshake completes while rst is high.
- Latency: a word accepted at edge n is visible on out_dataT/out_valid[T] after edge n (one cycle).
- Throughput: one word per cycle sustained, provided the target consumer holds out_ready high.
- With out_ready[T]=0 and slot T full, in_ready=0 until the edge at which the consumer pops.

## Structure
- Package module_demux_pkg holds:
  - NUM_OUT=4 and SEL_W=2;
  - named select constants SEL_OUT0..SEL_OUT3 = 2'b00..2'b11.
- Sub-module module_out_slot: a one-entry WIDTH register with valid, load and pop. Instantiated four times.
- The top level holds the target decode, rr_ptr, xfer_count and the in_ready logic.

## Test plan
- Reset, then rr_en=0, out_ready=1111, and 4 words A0..A3 with in_sel 00,10,01,11 in consecutive cycles → each word appears one cycle later on outputs 0,2,1,3 respectively; xfer_count=4.
- out_ready[2]=0, push 0x11 to sel 10, then 0x22 to sel 10 → second word stalls with in_ready=0. Raise out_ready[2] → 0x11 pops and 0x22 loads on the same edge, with out_valid[2] staying 1.
- rr_en=1, out_ready=1111, 6 back-to-back words → outputs 0,1,2,3,0,1 in order; rr_ptr ends at 2.
- rr_en=1 with slot 1 held full (out_ready[1]=0) and rr_ptr=1 → in_ready=0 and rr_ptr holds. Release out_ready[1] → transfer completes and rr_ptr becomes 2.
- Assert rst asynchronously while all 4 slots are full and xfer_count=7 → out_valid=0000, xfer_count=0, rr_ptr=0 without waiting for a clk edge.
- COUNT_W=4: push 17 words → xfer_count wraps to 1.

Source files
------------

// File: rtl/module_demux_pkg.sv
// Shared constants for the registered 1-to-4 result demultiplexer.
// Select codes map {s1,s0} directly onto output slot indices.
package module_demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  localparam logic [SEL_W-1:0] SEL_OUT0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_OUT1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_OUT2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_OUT3 = 2'b11;

  // Round-robin pointer step; the natural 2-bit wrap gives 3 -> 0.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr);
    return SEL_W'(ptr + 1'b1);
  endfunction

endpackage

// File: rtl/module_out_slot.sv
// One-entry output register with valid flag. A load in the same cycle as a
// pop wins, so a consumer draining every cycle never sees a bubble.
module module_out_slot
  import module_demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             ready,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  assign free = !valid || ready;

  // Data is left stale after a pop; only valid tells the consumer anything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/module_demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer: one result stream steered to four consumers,
// either by in_sel or by a round-robin pointer that advances on accepted words.
module module_demux_1x4_reg
  import module_demux_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 rr_en,
  output logic [NUM_OUT-1:0]   out_valid,
  input  logic [NUM_OUT-1:0]   out_ready,
  output logic [WIDTH-1:0]     out_data0,
  output logic [WIDTH-1:0]     out_data1,
  output logic [WIDTH-1:0]     out_data2,
  output logic [WIDTH-1:0]     out_data3,
  output logic [COUNT_W-1:0]   xfer_count
);

  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   tgt;
  logic [NUM_OUT-1:0] slot_free;
  logic [NUM_OUT-1:0] load;
  logic               accept;
  logic [WIDTH-1:0]   slot_data [NUM_OUT];

  assign tgt      = rr_en ? rr_ptr : in_sel;
  assign in_ready = slot_free[tgt];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load = '0;
    unique case (tgt)
      SEL_OUT0: load[0] = accept;
      SEL_OUT1: load[1] = accept;
      SEL_OUT2: load[2] = accept;
      SEL_OUT3: load[3] = accept;
    endcase
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    module_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .ready (out_ready[k]),
      .din   (in_data),
      .valid (out_valid[k]),
      .data  (slot_data[k]),
      .free  (slot_free[k])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

  // The pointer only moves on words it actually steered, so toggling rr_en
  // resumes round-robin where it left off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      xfer_count <= '0;
    end else if (accept) begin
      xfer_count <= xfer_count + 1'b1;
      if (rr_en) rr_ptr <= rr_next(rr_ptr);
    end
  end

endmodule
